// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg
//   Shared definitions for the sequential restoring divider (div_32) and its
//   combinational iteration stage (div_step).
//
//   Contents:
//     N_DEFAULT     default operand width (divisor / quotient / remainder)
//     CNT_W_DEFAULT iteration counter width able to hold N_DEFAULT
//     state_e       ASM controller states
// -----------------------------------------------------------------------------
package div_pkg;

    localparam int unsigned N_DEFAULT     = 16;
    localparam int unsigned CNT_W_DEFAULT = $clog2(N_DEFAULT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ITER  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage : div_pkg

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One combinational restoring-division iteration.
//
//   Ports:
//     r_i  [N-1:0]  current partial remainder (must be < d_i)
//     q_i  [N-1:0]  current dividend-low / quotient shift register
//     d_i  [N-1:0]  divisor
//     r_o  [N-1:0]  next partial remainder
//     q_o  [N-1:0]  next shift register, new quotient bit in the LSB
// -----------------------------------------------------------------------------
module div_step
    import div_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic [N-1:0] r_i,
    input  logic [N-1:0] q_i,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] r_o,
    output logic [N-1:0] q_o
);

    // The bit shifted out of R is kept as the MSB of the trial value so that
    // divisors >= 2^(N-1) still compare correctly.
    logic [N:0] trial;
    logic [N:0] diff;

    always_comb begin
        trial = {r_i, q_i[N-1]};
        diff  = trial - {1'b0, d_i};
        if (!diff[N]) begin
            r_o = diff[N-1:0];
            q_o = {q_i[N-2:0], 1'b1};
        end else begin
            r_o = trial[N-1:0];
            q_o = {q_i[N-2:0], 1'b0};
        end
    end

endmodule : div_step

// File: rtl/div_32.sv
// -----------------------------------------------------------------------------
// div_32
//   Sequential unsigned restoring divider: 2N-bit dividend / N-bit divisor,
//   one quotient bit per clock, init/done handshake shared with the
//   shift-add multiplier core.
//
//   Ports:
//     clk        system clock, rising edge
//     rst        synchronous active-low reset
//     init       start request, only honoured in IDLE
//     dividend   [2N-1:0] numerator, captured on the accept edge
//     divisor    [N-1:0]  denominator, captured on the accept edge
//     quotient   [N-1:0]  registered quotient (all ones on error)
//     remainder  [N-1:0]  registered remainder (zero on error)
//     busy       high whenever the controller is not in IDLE
//     done       one-cycle pulse, results valid
//     err        divide-by-zero or quotient overflow; held until next accept
// -----------------------------------------------------------------------------
module div_32
    import div_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           init,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [N-1:0]   quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam int unsigned CW = $clog2(N + 1);

    state_e         state_q, state_d;
    logic [N-1:0]   r_q, r_d;
    logic [N-1:0]   q_q, q_d;
    logic [N-1:0]   d_q, d_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   quo_q, quo_d;
    logic [N-1:0]   rem_q, rem_d;
    logic           err_q, err_d;

    logic [N-1:0]   step_r;
    logic [N-1:0]   step_q;

    div_step #(
        .N (N)
    ) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (d_q),
        .r_o (step_r),
        .q_o (step_q)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (init) begin
                    r_d     = dividend[2*N-1:N];
                    q_d     = dividend[N-1:0];
                    d_d     = divisor;
                    cnt_d   = CW'(N);
                    err_d   = 1'b0;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                // A high half >= divisor means the quotient needs more than
                // N bits; divisor == 0 is caught by the same compare but is
                // kept explicit for readability.
                if ((d_q == '0) || (r_q >= d_q)) begin
                    err_d   = 1'b1;
                    quo_d   = '1;
                    rem_d   = '0;
                    state_d = DONE;
                end else begin
                    state_d = ITER;
                end
            end

            ITER: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    quo_d   = step_q;
                    rem_d   = step_r;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign err       = err_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule : div_32

// File: tb/tb_div_32.sv
module tb_div_32;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          init;
    logic [31:0]   dividend;
    logic [15:0]   divisor;
    logic [15:0]   quotient;
    logic [15:0]   remainder;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    div_32 #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .init      (init),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference division from the arithmetic rules alone.
    function automatic void ref_div(input logic [31:0] a, input logic [15:0] b,
                                    output logic [15:0] q, output logic [15:0] r,
                                    output logic e);
        if (b == 16'd0 || (a / {16'd0, b}) > 32'h0000_FFFF) begin
            q = 16'hFFFF;
            r = 16'h0000;
            e = 1'b1;
        end else begin
            q = 16'(a / {16'd0, b});
            r = 16'(a % {16'd0, b});
            e = 1'b0;
        end
    endfunction

    // Transaction-level timing model: m_left counts cycles until IDLE again.
    bit          m_valid = 1'b0;
    int          m_left  = 0;
    logic [15:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;
    logic        m_err = 1'b0, p_err = 1'b0;
    logic [31:0] m_a = '0;
    logic [15:0] m_b = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_valid = 1'b1;
            m_left  = 0;
            m_q     = '0;
            m_r     = '0;
            m_err   = 1'b0;
        end else if (m_valid) begin
            if (m_left == 0) begin
                if (init) begin
                    ref_div(dividend, divisor, p_q, p_r, p_err);
                    m_a    = dividend;
                    m_b    = divisor;
                    m_err  = 1'b0;
                    m_left = p_err ? 2 : N + 2;
                end
            end else begin
                m_left--;
                if (m_left == 1) begin
                    m_q   = p_q;
                    m_r   = p_r;
                    m_err = p_err;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy",      64'(busy),      64'(m_left != 0));
            chk("done",      64'(done),      64'(m_left == 1));
            chk("quotient",  64'(quotient),  64'(m_q));
            chk("remainder", 64'(remainder), 64'(m_r));
            chk("err",       64'(err),       64'(m_err));
            if (m_left == 1 && !m_err) begin
                chk("invariant", 64'(quotient) * 64'(m_b) + 64'(remainder), 64'(m_a));
                chk("rem_lt_div", 64'(remainder < m_b), 64'd1);
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("wait_idle", 64'(busy), 64'd0);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [15:0] b, input bit lit,
                         input logic [15:0] eq, input logic [15:0] er, input logic ee,
                         input bit toggle);
        int k = 0;
        wait_idle();
        dividend = a;
        divisor  = b;
        init     = 1'b1;
        @(negedge clk);
        init     = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
            if (toggle) init = (k < 10) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        init = 1'b0;
        if (k >= 40) begin
            chk("done_timeout", 64'(done), 64'd1);
        end else if (lit) begin
            chk("latency",      64'(k),         ee ? 64'd1 : 64'(N + 1));
            chk("lit_quotient", 64'(quotient),  64'(eq));
            chk("lit_remainder",64'(remainder), 64'(er));
            chk("lit_err",      64'(err),       64'(ee));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] tq, tr;
        logic        te;
        int          seen, last, t;
        bit          saw_done;
        logic [15:0] b;
        logic [31:0] a;

        rst = 1'b0; init = 1'b0; dividend = '0; divisor = '0;

        ref_div(32'h0000_0064, 16'h0007, tq, tr, te);
        chk("model_q_100_7", 64'(tq), 64'h000E);
        chk("model_r_100_7", 64'(tr), 64'h0002);
        ref_div(32'hFFFE_FFFF, 16'hFFFF, tq, tr, te);
        chk("model_q_max", 64'(tq), 64'hFFFF);
        chk("model_r_max", 64'(tr), 64'hFFFE);
        ref_div(32'h0001_0000, 16'h0001, tq, tr, te);
        chk("model_ovf", 64'(te), 64'd1);

        repeat (2) @(negedge clk);
        chk("rst_quotient",  64'(quotient),  64'd0);
        chk("rst_remainder", 64'(remainder), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_err",       64'(err),       64'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op(32'h0000_7A89, 16'h007F, 1, 16'h00F7, 16'h0000, 0, 0);
        do_op(32'h0000_0064, 16'h0007, 1, 16'h000E, 16'h0002, 0, 0);
        do_op(32'h000F_4240, 16'h03E8, 1, 16'h03E8, 16'h0000, 0, 0);
        do_op(32'hFFFE_FFFF, 16'hFFFF, 1, 16'hFFFF, 16'hFFFE, 0, 0);
        do_op(32'h1234_5678, 16'h0000, 1, 16'hFFFF, 16'h0000, 1, 0);
        do_op(32'h0001_0000, 16'h0001, 1, 16'hFFFF, 16'h0000, 1, 0);
        repeat (3) @(negedge clk);
        chk("err_held", 64'(err), 64'd1);
        do_op(32'h0000_0064, 16'h0007, 1, 16'h000E, 16'h0002, 0, 0);

        // init held high: back-to-back operations
        wait_idle();
        dividend = 32'h0000_7A89;
        divisor  = 16'h007F;
        init     = 1'b1;
        seen = 0; last = -1; t = 0;
        while (seen < 3 && t < 200) begin
            @(negedge clk);
            t++;
            if (done === 1'b1) begin
                if (last >= 0) chk("hold_period", 64'(t - last), 64'd19);
                last = t;
                seen++;
            end
        end
        init = 1'b0;
        chk("hold_pulses", 64'(seen), 64'd3);

        // init toggled while busy
        do_op(32'h0000_7A89, 16'h007F, 1, 16'h00F7, 16'h0000, 0, 1);

        // reset in the middle of the iterations
        wait_idle();
        dividend = 32'h0000_7A89;
        divisor  = 16'h007F;
        init     = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("midrst_quotient",  64'(quotient),  64'd0);
        chk("midrst_remainder", 64'(remainder), 64'd0);
        chk("midrst_busy",      64'(busy),      64'd0);
        chk("midrst_done",      64'(done),      64'd0);
        chk("midrst_err",       64'(err),       64'd0);
        saw_done = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        chk("midrst_no_done", 64'(saw_done), 64'd0);
        do_op(32'h000F_4240, 16'h03E8, 1, 16'h03E8, 16'h0000, 0, 0);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 9))
                0:       b = 16'h0000;
                1, 2, 3: b = 16'h8000 | 16'($urandom);
                default: b = 16'($urandom_range(1, 16'hFFFF));
            endcase
            if (b != 16'h0000 && $urandom_range(0, 3) != 0)
                a = {16'($urandom % {16'd0, b}), 16'($urandom)};
            else
                a = $urandom;
            do_op(a, b, 0, '0, '0, 0, ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_div_32
